// File: rtl/rule_conf_loader_pkg.sv
// rule_conf_loader_pkg: FSM states, config subtype codes, command record and address helper.
// Width macros are global; defaults apply only when the build leaves them undefined.
`ifndef RULE_NUM
`define RULE_NUM 64
`endif
`ifndef TYPE_NUM
`define TYPE_NUM 4
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 16
`endif
`ifndef KEY_FILED_NUM
`define KEY_FILED_NUM 8
`endif
`ifndef KEY_OFFSET_WIDTH
`define KEY_OFFSET_WIDTH 8
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 8
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 8
`endif

package rule_conf_loader_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_TYPE, ST_KEY, ST_HEAD, ST_META, ST_COMMIT} state_t;
    localparam logic [2:0] SUB_COMMIT = 3'd0;
    localparam logic [2:0] SUB_TYPE   = 3'd1;
    localparam logic [2:0] SUB_KEY    = 3'd2;
    localparam logic [2:0] SUB_HEAD   = 3'd3;
    localparam logic [2:0] SUB_META   = 3'd4;
    localparam int RULE_SEL_BIT = 16;
    typedef struct packed {
        logic [5:0]                                            rule_id;
        logic                                                  rule_valid;
        logic [`TYPE_NUM-1:0][`TYPE_WIDTH-1:0]                 type_data;
        logic [`TYPE_NUM-1:0][`TYPE_WIDTH-1:0]                 type_mask;
        logic [`KEY_FILED_NUM-1:0][`KEY_OFFSET_WIDTH-1:0]      key_offset;
        logic [`HEAD_SHIFT_WIDTH-1:0]                          head_shift;
        logic [`META_SHIFT_WIDTH-1:0]                          meta_shift;
    } cmd_t;
    function automatic logic [31:0] cfg_addr(input logic [2:0] sub, input logic [7:0] idx);
        logic [31:0] a;
        a = '0;
        a[RULE_SEL_BIT] = 1'b1;
        a[10:8] = sub;
        a[7:0] = idx;
        return a;
    endfunction
endpackage

// File: rtl/rule_conf_loader.sv
// rule_conf_loader: streams one rule command as config writes TYPE, KEY, HEAD, META, then COMMIT.
// Define RULE_LOADER_PACE_EN to insert one idle cycle between consecutive writes.
module rule_conf_loader
    import rule_conf_loader_pkg::*;
(
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_cmd_valid,
    output logic                                        o_cmd_ready,
    input  logic [5:0]                                  i_cmd_ruleId,
    input  logic                                        i_cmd_ruleValid,
    input  logic [`TYPE_NUM-1:0][`TYPE_WIDTH-1:0]       i_cmd_typeData,
    input  logic [`TYPE_NUM-1:0][`TYPE_WIDTH-1:0]       i_cmd_typeMask,
    input  logic [`KEY_FILED_NUM-1:0][`KEY_OFFSET_WIDTH-1:0] i_cmd_keyOffset,
    input  logic [`HEAD_SHIFT_WIDTH-1:0]                i_cmd_headShift,
    input  logic [`META_SHIFT_WIDTH-1:0]                i_cmd_metaShift,
    output logic                                        o_rule_wren,
    output logic [31:0]                                 o_rule_wdata,
    output logic [31:0]                                 o_rule_addr,
    output logic                                        o_done
);
`ifdef RULE_LOADER_PACE_EN
    localparam bit PACE = 1'b1;
`else
    localparam bit PACE = 1'b0;
`endif
    localparam int TW = $clog2(`TYPE_NUM);
    localparam int KW = $clog2(`KEY_FILED_NUM);
    localparam int CW = TW > KW ? TW : KW;
    localparam logic [CW-1:0] TYPE_LAST = CW'(`TYPE_NUM - 1);
    localparam logic [CW-1:0] KEY_LAST  = CW'(`KEY_FILED_NUM - 1);

    state_t        r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_gap, w_gap, w_accept;
    cmd_t          r_cmd, w_cmd;
    logic [31:0]   w_addr, w_wdata;
    logic          r_ready, r_wren, r_done;
    logic [31:0]   r_addr, r_wdata;

    assign w_accept = i_cmd_valid && r_ready;
    assign w_cmd = w_accept ? {i_cmd_ruleId, i_cmd_ruleValid, i_cmd_typeData, i_cmd_typeMask,
                               i_cmd_keyOffset, i_cmd_headShift, i_cmd_metaShift} : r_cmd;

    // State/counter name the write issued next; a pacing gap holds them for one silent cycle.
    always_comb begin
        w_state = r_state;
        w_cnt = r_cnt;
        w_gap = 1'b0;
        if (r_state == ST_IDLE) begin
            w_state = w_accept ? ST_TYPE : ST_IDLE;
            w_cnt = '0;
        end else if (PACE && !r_gap && r_state != ST_COMMIT) begin
            w_gap = 1'b1;
        end else begin
            case (r_state)
                ST_TYPE: begin
                    w_state = r_cnt == TYPE_LAST ? ST_KEY : ST_TYPE;
                    w_cnt = r_cnt == TYPE_LAST ? '0 : r_cnt + CW'(1);
                end
                ST_KEY: begin
                    w_state = r_cnt == KEY_LAST ? ST_HEAD : ST_KEY;
                    w_cnt = r_cnt == KEY_LAST ? '0 : r_cnt + CW'(1);
                end
                ST_HEAD: w_state = ST_META;
                ST_META: w_state = ST_COMMIT;
                default: w_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_addr = '0;
        w_wdata = '0;
        case (w_state)
            ST_TYPE: begin
                w_addr = cfg_addr(SUB_TYPE, 8'(w_cnt));
                w_wdata[16 +: `TYPE_WIDTH] = w_cmd.type_data[w_cnt[TW-1:0]];
                w_wdata[0 +: `TYPE_WIDTH] = w_cmd.type_mask[w_cnt[TW-1:0]];
            end
            ST_KEY: begin
                w_addr = cfg_addr(SUB_KEY, 8'(w_cnt));
                w_wdata[0 +: `KEY_OFFSET_WIDTH] = w_cmd.key_offset[w_cnt[KW-1:0]];
            end
            ST_HEAD: begin
                w_addr = cfg_addr(SUB_HEAD, 8'd0);
                w_wdata[0 +: `HEAD_SHIFT_WIDTH] = w_cmd.head_shift;
            end
            ST_META: begin
                w_addr = cfg_addr(SUB_META, 8'd0);
                w_wdata[0 +: `META_SHIFT_WIDTH] = w_cmd.meta_shift;
            end
            ST_COMMIT: begin
                w_addr = cfg_addr(SUB_COMMIT, 8'(w_cmd.rule_id));
                w_wdata[0] = w_cmd.rule_valid;
            end
            default: ;
        endcase
        if (w_gap) begin
            w_addr = '0;
            w_wdata = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gap   <= 1'b0;
            r_cmd   <= '0;
            r_ready <= 1'b0;
            r_wren  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_cmd   <= w_cmd;
            r_ready <= w_state == ST_IDLE;
            r_wren  <= w_state != ST_IDLE && !w_gap;
            r_done  <= w_state == ST_COMMIT;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end
    end

    assign o_cmd_ready  = r_ready;
    assign o_rule_wren  = r_wren;
    assign o_rule_wdata = r_wdata;
    assign o_rule_addr  = r_addr;
    assign o_done       = r_done;
endmodule

// File: tb/tb_rule_conf_loader.sv
// tb_rule_conf_loader: random and directed commands checked every cycle against a write-list model.
// Honours RULE_LOADER_PACE_EN the same way the design does.
`ifndef TYPE_NUM
`define TYPE_NUM 4
`endif
`ifndef TYPE_WIDTH
`define TYPE_WIDTH 16
`endif
`ifndef KEY_FILED_NUM
`define KEY_FILED_NUM 8
`endif
`ifndef KEY_OFFSET_WIDTH
`define KEY_OFFSET_WIDTH 8
`endif
`ifndef HEAD_SHIFT_WIDTH
`define HEAD_SHIFT_WIDTH 8
`endif
`ifndef META_SHIFT_WIDTH
`define META_SHIFT_WIDTH 8
`endif

module tb_rule_conf_loader;
`ifdef RULE_LOADER_PACE_EN
    localparam bit PACE = 1'b1;
`else
    localparam bit PACE = 1'b0;
`endif
    localparam int TN = `TYPE_NUM;
    localparam int KN = `KEY_FILED_NUM;
    localparam int N = TN + KN + 3;
    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } beat_t;
    localparam beat_t IDLE_B = '{1'b0, 32'd0, 32'd0, 1'b0};

    logic i_clk = 1'b0;
    logic i_rst_n, i_cmd_valid, i_cmd_ruleValid;
    logic o_cmd_ready, o_rule_wren, o_done;
    logic [5:0] i_cmd_ruleId;
    logic [TN-1:0][`TYPE_WIDTH-1:0] i_cmd_typeData, i_cmd_typeMask;
    logic [KN-1:0][`KEY_OFFSET_WIDTH-1:0] i_cmd_keyOffset;
    logic [`HEAD_SHIFT_WIDTH-1:0] i_cmd_headShift;
    logic [`META_SHIFT_WIDTH-1:0] i_cmd_metaShift;
    logic [31:0] o_rule_wdata, o_rule_addr;

    always #5 i_clk = ~i_clk;

    rule_conf_loader dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_ruleId(i_cmd_ruleId), .i_cmd_ruleValid(i_cmd_ruleValid),
        .i_cmd_typeData(i_cmd_typeData), .i_cmd_typeMask(i_cmd_typeMask),
        .i_cmd_keyOffset(i_cmd_keyOffset), .i_cmd_headShift(i_cmd_headShift),
        .i_cmd_metaShift(i_cmd_metaShift), .o_rule_wren(o_rule_wren),
        .o_rule_wdata(o_rule_wdata), .o_rule_addr(o_rule_addr), .o_done(o_done)
    );

    beat_t exp_q[$];
    beat_t seen[$];
    beat_t cur = IDLE_B;
    int seen_cyc[$];
    int acc_cyc[$];
    bit m_ready = 1'b0;
    bit m_on = 1'b0;
    int cyc = 0;
    int chk = 0;
    int err = 0;

    // Snapshot the command into the full list of writes it must produce, gaps included.
    task automatic build();
        beat_t w[$];
        for (int i = 0; i < TN; i++)
            w.push_back('{1'b1, 32'(32'h10100 + i),
                          (32'(i_cmd_typeData[i]) << 16) | 32'(i_cmd_typeMask[i]), 1'b0});
        for (int i = 0; i < KN; i++)
            w.push_back('{1'b1, 32'(32'h10200 + i), 32'(i_cmd_keyOffset[i]), 1'b0});
        w.push_back('{1'b1, 32'h10300, 32'(i_cmd_headShift), 1'b0});
        w.push_back('{1'b1, 32'h10400, 32'(i_cmd_metaShift), 1'b0});
        w.push_back('{1'b1, 32'(32'h10000 + i_cmd_ruleId), 32'(i_cmd_ruleValid), 1'b1});
        foreach (w[k]) begin
            exp_q.push_back(w[k]);
            if (PACE && k != w.size() - 1) exp_q.push_back(IDLE_B);
        end
    endtask

    always @(posedge i_clk) begin
        cyc++;
        if (!i_rst_n) begin
            exp_q.delete();
            cur = IDLE_B;
            m_ready = 1'b0;
            m_on = 1'b1;
        end else if (m_on) begin
            if (i_cmd_valid && m_ready) begin
                build();
                acc_cyc.push_back(cyc);
            end
            cur = IDLE_B;
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            m_ready = exp_q.size() == 0 && !cur.wren;
        end
    end

    always @(negedge i_clk) begin
        if (m_on) begin
            chk++;
            if (o_cmd_ready !== m_ready || o_rule_wren !== cur.wren || o_rule_addr !== cur.addr ||
                o_rule_wdata !== cur.data || o_done !== cur.done) begin
                err++;
                $display("FAIL cycle %0d: got rdy=%b wren=%b addr=%h data=%h done=%b, need rdy=%b wren=%b addr=%h data=%h done=%b",
                         cyc, o_cmd_ready, o_rule_wren, o_rule_addr, o_rule_wdata, o_done,
                         m_ready, cur.wren, cur.addr, cur.data, cur.done);
            end
            if (o_rule_wren === 1'b1) begin
                seen.push_back('{1'b1, o_rule_addr, o_rule_wdata, o_done});
                seen_cyc.push_back(cyc);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
        chk++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %h need %h", name, got, want);
        end
    endtask

    task automatic scramble();
        i_cmd_ruleId = 6'($urandom);
        i_cmd_ruleValid = 1'($urandom);
        for (int i = 0; i < TN; i++) begin
            i_cmd_typeData[i] = `TYPE_WIDTH'($urandom);
            i_cmd_typeMask[i] = `TYPE_WIDTH'($urandom);
        end
        for (int i = 0; i < KN; i++) i_cmd_keyOffset[i] = `KEY_OFFSET_WIDTH'($urandom);
        i_cmd_headShift = `HEAD_SHIFT_WIDTH'($urandom);
        i_cmd_metaShift = `META_SHIFT_WIDTH'($urandom);
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 200 && (exp_q.size() > 0 || cur.wren); k++) begin
            tick();
            scramble();
        end
        lit("idle_timeout", 32'(exp_q.size() > 0 || cur.wren), 32'd0);
    endtask

    task automatic wait_acc(input int target);
        for (int k = 0; k < 200 && acc_cyc.size() < target; k++) tick();
        lit("accept_timeout", 32'(acc_cyc.size() >= target), 32'd1);
    endtask

    int base;
    int a0;
    int hits;

    initial begin
        i_rst_n = 1'b0;
        i_cmd_valid = 1'b0;
        scramble();
        repeat (3) tick();
        i_rst_n = 1'b1;
        tick();
        lit("ready_after_reset", 32'(o_cmd_ready), 32'd1);
        lit("wren_after_reset", 32'(o_rule_wren), 32'd0);
        repeat (20) tick();
        lit("idle_no_writes", 32'(seen.size()), 32'd0);

        base = seen.size();
        scramble();
        i_cmd_ruleId = 6'd5;
        i_cmd_ruleValid = 1'b1;
        i_cmd_typeData[2] = `TYPE_WIDTH'(16'h0800);
        i_cmd_typeMask[2] = `TYPE_WIDTH'(16'hFFFF);
        i_cmd_keyOffset[7] = `KEY_OFFSET_WIDTH'(8'h2A);
        i_cmd_headShift = `HEAD_SHIFT_WIDTH'(14);
        i_cmd_metaShift = `META_SHIFT_WIDTH'(3);
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        wait_idle();
        lit("cmd1_nwrites", 32'(seen.size() - base), 32'(N));
        if (seen.size() - base == N) begin
            lit("cmd1_w3_addr", seen[base + 2].addr, 32'h00010102);
            lit("cmd1_w3_data", seen[base + 2].data, 32'h0800FFFF);
            lit("cmd1_key7", {seen[base + 11].addr[15:0], seen[base + 11].data[15:0]}, 32'h0207002A);
            lit("cmd1_head", {seen[base + 12].addr[15:0], seen[base + 12].data[15:0]}, 32'h0300000E);
            lit("cmd1_meta", {seen[base + 13].addr[15:0], seen[base + 13].data[15:0]}, 32'h04000003);
            lit("cmd1_commit_addr", seen[base + 14].addr, 32'h00010005);
            lit("cmd1_commit_data", seen[base + 14].data, 32'h1);
            lit("cmd1_commit_done", 32'(seen[base + 14].done), 32'd1);
            lit("cmd1_span", 32'(seen_cyc[base + 14] - seen_cyc[base] + 1), PACE ? 32'd29 : 32'd15);
            lit("cmd1_latency", 32'(seen_cyc[base] - acc_cyc[acc_cyc.size() - 1]), 32'd0);
        end

        a0 = acc_cyc.size();
        scramble();
        i_cmd_valid = 1'b1;
        wait_acc(a0 + 1);
        scramble();
        wait_acc(a0 + 2);
        i_cmd_valid = 1'b0;
        if (acc_cyc.size() >= a0 + 2)
            lit("b2b_gap", 32'(acc_cyc[a0 + 1] - acc_cyc[a0]), PACE ? 32'(2 * N) : 32'(N + 1));
        wait_idle();

        base = seen.size();
        scramble();
        i_cmd_ruleId = 6'd5;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
        for (int k = 0; k < 100 && seen.size() < base + 6; k++) tick();
        lit("reached_6th_write", 32'(seen.size() - base), 32'd6);
        i_rst_n = 1'b0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        lit("rst_mid_ready", 32'(o_cmd_ready), 32'd1);
        lit("rst_mid_wren", 32'(o_rule_wren), 32'd0);
        repeat (20) tick();
        hits = 0;
        for (int k = base; k < seen.size(); k++) if (seen[k].addr == 32'h10005) hits++;
        lit("rst_no_commit", 32'(hits), 32'd0);
        lit("rst_no_resume", 32'(seen.size() - base), 32'd6);

        for (int k = 0; k < 1500; k++) begin
            scramble();
            i_cmd_valid = $urandom_range(0, 2) == 0;
            i_rst_n = $urandom_range(0, 299) != 0;
            tick();
        end
        i_rst_n = 1'b1;
        i_cmd_valid = 1'b0;
        wait_idle();
        lit("random_accepts_seen", 32'(acc_cyc.size() > a0 + 6), 32'd1);
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule

// File: doc/rule_conf_loader.md
RULE_CONF_LOADER -- requirements
Module: rule_conf_loader

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port i_cmd_valid, input, 1, rule command present.
REQ-004 SHALL have port o_cmd_ready, output, 1, loader accepts command.
REQ-005 SHALL have port i_cmd_ruleId, input, 6, target rule index (< `RULE_NUM).
REQ-006 SHALL have port i_cmd_ruleValid, input, 1, valid bit committed with rule.
REQ-007 SHALL have port i_cmd_typeData, input, [`TYPE_NUM-1:0][`TYPE_WIDTH-1:0], type match data.
REQ-008 SHALL have port i_cmd_typeMask, input, [`TYPE_NUM-1:0][`TYPE_WIDTH-1:0], type match mask.
REQ-009 SHALL have port i_cmd_keyOffset, input, [`KEY_FILED_NUM-1:0][`KEY_OFFSET_WIDTH-1:0], key field offsets.
REQ-010 SHALL have port i_cmd_headShift, input, `HEAD_SHIFT_WIDTH, header shift.
REQ-011 SHALL have port i_cmd_metaShift, input, `META_SHIFT_WIDTH, meta shift.
REQ-012 SHALL have port o_rule_wren, output, 1, config write strobe to the rule configuration port.
REQ-013 SHALL have port o_rule_wdata, output, 32, config write data.
REQ-014 SHALL have port o_rule_addr, output, 32, config write address.
REQ-015 SHALL have port o_done, output, 1, one-cycle pulse on the commit write.

Function
REQ-016 Address map driven: addr[16]=1 selects rule writes; addr[10:8] = subtype; all other address bits 0.
REQ-017 Handshake: command accepted when i_cmd_valid && o_cmd_ready; o_cmd_ready=1 only in IDLE; all command fields registered on acceptance.
REQ-018 FSM states IDLE, TYPE, KEY, HEAD, META, COMMIT; one write per cycle; index counter cleared on entry to each state.
REQ-019 TYPE: `TYPE_NUM writes, i=0..; addr = 0x10000|0x100|i; wdata[16+:`TYPE_WIDTH]=typeData[i], wdata[0+:`TYPE_WIDTH]=typeMask[i], other bits 0.
REQ-020 KEY: `KEY_FILED_NUM writes; addr = 0x10000|0x200|i; wdata[0+:`KEY_OFFSET_WIDTH]=keyOffset[i], rest 0.
REQ-021 HEAD: one write, addr 0x10300, wdata = zero-extended headShift; META: one write, addr 0x10400, wdata = zero-extended metaShift.
REQ-022 COMMIT: one write, addr = 0x10000|ruleId, wdata = {31'b0, ruleValid}; o_done=1 same cycle; next state IDLE.
REQ-023 Timing: acceptance at edge T -> first write in cycle T+1; N=`TYPE_NUM+`KEY_FILED_NUM+3 consecutive writes; o_cmd_ready high again cycle after COMMIT.
REQ-024 COMMIT strictly last, so a rule becomes valid only after all its fields are written.
REQ-025 Outputs registered; o_rule_wdata/o_rule_addr are 0 whenever o_rule_wren=0.
REQ-026 i_cmd_* changes after acceptance have no effect on the sequence in flight.

Reset
REQ-027 When i_rst_n=0 at a clock edge: state=IDLE, counter=0, o_rule_wren=0, o_rule_wdata=0, o_rule_addr=0, o_done=0, o_cmd_ready=0 in the reset cycle, 1 in the first cycle after reset release.
REQ-028 Reset mid-sequence aborts without a COMMIT write; no partial write continues after release.

Configuration
REQ-029 Macro RULE_LOADER_PACE_EN defined: one idle cycle (wren=0) between consecutive writes; N writes span 2N-1 cycles; o_done still on the COMMIT write.
REQ-030 Macro RULE_LOADER_PACE_EN undefined: back-to-back writes per REQ-023.

Structure
REQ-031 The state enum and subtype codes (TYPE=1, KEY=2, HEAD=3, META=4, COMMIT=0) and the rule-select bit index 16 SHALL live in the shared parser package; width macros remain global.
REQ-032 Single flat module; no sub-module.

Verification (bench: TYPE_NUM=4, KEY_FILED_NUM=8)
REQ-033 Reset, then idle: o_cmd_ready=1, o_rule_wren=0 for 20 cycles.
REQ-034 Command ruleId=5, ruleValid=1, typeData[2]=0x0800, typeMask[2]=0xFFFF -> 15 writes from T+1; 3rd write addr 0x10102, wdata 0x0800FFFF; last write addr 0x10005, wdata 0x1, o_done=1.
REQ-035 keyOffset[7]=0x2A, headShift=14, metaShift=3 -> writes (0x10207,0x2A), (0x10300,14), (0x10400,3) in order.
REQ-036 i_cmd_valid held high for two commands -> o_cmd_ready low for 15 cycles; second sequence starts at the earliest T+16, no overlap.
REQ-037 Reset asserted at 6th write -> no write to addr 0x10005; after release o_cmd_ready=1, o_rule_wren=0.
REQ-038 RULE_LOADER_PACE_EN defined -> 15 writes over 29 cycles, wren alternating 1/0.
